// File: rtl/clipped_arc_if.sv
// Shape-engine bus between the shape sequencer (master) and clipped_arc (slave).
// Carries the start/done handshake, the latched draw parameters and the VGA plot port.
// Ports: start/done handshake; centre, radius, colour, octant mask, clip box; vga_x/y/colour/plot.
interface clipped_arc_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int RW = 8,
    parameter int CW = 3
);
    logic          start;
    logic          done;
    logic [XW-1:0] centre_x;
    logic [YW-1:0] centre_y;
    logic [RW-1:0] radius;
    logic [CW-1:0] colour;
    logic [7:0]    octant_mask;
    logic [XW-1:0] clip_xmin;
    logic [XW-1:0] clip_xmax;
    logic [YW-1:0] clip_ymin;
    logic [YW-1:0] clip_ymax;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    // Sequencer side: issues requests, watches done and the pixel stream.
    modport master (
        output start, centre_x, centre_y, radius, colour, octant_mask,
               clip_xmin, clip_xmax, clip_ymin, clip_ymax,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    // Engine side.
    modport slave (
        input  start, centre_x, centre_y, radius, colour, octant_mask,
               clip_xmin, clip_xmax, clip_ymin, clip_ymax,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/clipped_arc.sv
// Midpoint circle engine with per-octant enable mask and inclusive clip window, one candidate pixel per clock.
// Latency: 1 INIT cycle + 8 cycles per (ox,oy) iteration, then done; independent of mask/clip/screen.
// Backpressure: none on the plot port; start is a level request held until done, done held while start stays high.
// Ports: clk, rst (sync, active-high); bus = clipped_arc_if.slave (request/done, draw params, VGA plot port).
module clipped_arc #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int RW       = 8,
    parameter int CW       = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic         clk,
    input  logic         rst,
    clipped_arc_if.slave bus
);
    // Candidate width: wide enough that centre +/- radius never wraps.
    localparam int MW = (XW > YW) ? ((XW > RW) ? XW : RW) : ((YW > RW) ? YW : RW);
    localparam int SW = MW + 2;
    // Decision variable needs a little more headroom than the coordinates.
    localparam int DW = SW + 2;

    localparam logic signed [SW-1:0] ZERO_S = '0;
    localparam logic signed [DW-1:0] ZERO_D = '0;
    localparam logic signed [SW-1:0] SCR_W  = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] SCR_H  = SW'(SCREEN_H);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_PLOT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          cx_q, cx_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0]          cy_q, cy_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [RW-1:0]          r_q, r_d;
    logic [CW-1:0]          col_q, col_d;
    logic [7:0]             mask_q, mask_d;
    logic signed [SW-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic signed [DW-1:0]   crit_q, crit_d;
    logic [2:0]             oct_q, oct_d;

    // Datapath temporaries
    logic signed [SW-1:0]   cx_s, cy_s, dx, dy, cand_x, cand_y;
    logic signed [SW-1:0]   xmin_s, xmax_s, ymin_s, ymax_s;
    logic                   on_screen, in_clip;
    logic signed [SW-1:0]   ox_n, oy_n;
    logic signed [DW-1:0]   ox_w, oy_w;

    // Candidate pixel for the current octant, plus its visibility tests.
    always_comb begin
        cx_s   = $signed({{(SW-XW){1'b0}}, cx_q});
        cy_s   = $signed({{(SW-YW){1'b0}}, cy_q});
        xmin_s = $signed({{(SW-XW){1'b0}}, xmin_q});
        xmax_s = $signed({{(SW-XW){1'b0}}, xmax_q});
        ymin_s = $signed({{(SW-YW){1'b0}}, ymin_q});
        ymax_s = $signed({{(SW-YW){1'b0}}, ymax_q});
        dx     = ox_q;
        dy     = oy_q;
        case (oct_q)
            3'd0:    begin dx =  ox_q; dy =  oy_q; end
            3'd1:    begin dx =  oy_q; dy =  ox_q; end
            3'd2:    begin dx = -oy_q; dy =  ox_q; end
            3'd3:    begin dx = -ox_q; dy =  oy_q; end
            3'd4:    begin dx = -ox_q; dy = -oy_q; end
            3'd5:    begin dx = -oy_q; dy = -ox_q; end
            3'd6:    begin dx =  oy_q; dy = -ox_q; end
            default: begin dx =  ox_q; dy = -oy_q; end
        endcase
        cand_x    = cx_s + dx;
        cand_y    = cy_s + dy;
        on_screen = (cand_x >= ZERO_S) && (cand_x < SCR_W) &&
                    (cand_y >= ZERO_S) && (cand_y < SCR_H);
        // An inverted window (min > max) rejects everything naturally.
        in_clip   = (cand_x >= xmin_s) && (cand_x <= xmax_s) &&
                    (cand_y >= ymin_s) && (cand_y <= ymax_s);
    end

    // Next state and outputs
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        col_d   = col_q;
        mask_d  = mask_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        oct_d   = oct_q;
        ox_n    = ox_q;
        oy_n    = oy_q;
        ox_w    = {{(DW-SW){ox_q[SW-1]}}, ox_q};
        oy_w    = {{(DW-SW){oy_q[SW-1]}}, oy_q};

        bus.done       = 1'b0;
        bus.vga_plot   = 1'b0;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cx_d    = bus.centre_x;
                    cy_d    = bus.centre_y;
                    r_d     = bus.radius;
                    col_d   = bus.colour;
                    mask_d  = bus.octant_mask;
                    xmin_d  = bus.clip_xmin;
                    xmax_d  = bus.clip_xmax;
                    ymin_d  = bus.clip_ymin;
                    ymax_d  = bus.clip_ymax;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                ox_d    = $signed({{(SW-RW){1'b0}}, r_q});
                oy_d    = ZERO_S;
                crit_d  = DW'(1) - $signed({{(DW-RW){1'b0}}, r_q});
                oct_d   = 3'd0;
                state_d = S_PLOT;
            end
            S_PLOT: begin
                // Coordinates are presented every cycle; only the strobe is qualified.
                bus.vga_x      = cand_x[XW-1:0];
                bus.vga_y      = cand_y[YW-1:0];
                bus.vga_colour = col_q;
                bus.vga_plot   = mask_q[oct_q] && on_screen && in_clip;
                oct_d          = oct_q + 3'd1;
                if (oct_q == 3'd7) begin
                    oy_n = oy_q + SW'(1);
                    oy_w = {{(DW-SW){oy_n[SW-1]}}, oy_n};
                    if (crit_q <= ZERO_D) begin
                        crit_d = crit_q + (oy_w <<< 1) + DW'(1);
                    end else begin
                        ox_n   = ox_q - SW'(1);
                        ox_w   = {{(DW-SW){ox_n[SW-1]}}, ox_n};
                        crit_d = crit_q + ((oy_w - ox_w) <<< 1) + DW'(1);
                    end
                    ox_d = ox_n;
                    oy_d = oy_n;
                    if (oy_n > ox_n) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin // S_DONE
                bus.done = 1'b1;
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            col_q   <= '0;
            mask_q  <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            crit_q  <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            col_q   <= col_d;
            mask_q  <= mask_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            crit_q  <= crit_d;
            oct_q   <= oct_d;
        end
    end
endmodule

// File: tb/tb_clipped_arc.sv
module tb_clipped_arc;
    localparam int XW = 8, YW = 7, RW = 8, CW = 3;
    localparam int SCREEN_W = 160, SCREEN_H = 120;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clipped_arc_if #(.XW(XW), .YW(YW), .RW(RW), .CW(CW)) bus ();

    clipped_arc #(
        .XW(XW), .YW(YW), .RW(RW), .CW(CW),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];   // per PLOT cycle: {plot, x low bits, y low bits}
    bit          seen[int];  // pixels the DUT strobed, key x*256+y
    bit          gold[int];  // pixels the model says get strobed

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // Reference: walk the first octant arc with the midpoint rule, reflect each
    // point into the eight octants, and decide visibility with plain integers.
    task automatic build_model(input int cx, input int cy, input int r, input logic [7:0] mask,
                               input int xmin, input int xmax, input int ymin, input int ymax);
        int ox, oy, d;
        exp_q.delete();
        ox = r; oy = 0; d = 1 - r;
        while (oy <= ox) begin
            for (int k = 0; k < 8; k++) begin
                int px, py;
                bit p;
                logic [7:0] lx;
                logic [6:0] ly;
                case (k)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - oy; py = cy + ox; end
                    3: begin px = cx - ox; py = cy + oy; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + oy; py = cy - ox; end
                    default: begin px = cx + ox; py = cy - oy; end
                endcase
                p = mask[k] && px >= 0 && px < SCREEN_W && py >= 0 && py < SCREEN_H &&
                    px >= xmin && px <= xmax && py >= ymin && py <= ymax;
                lx = px[7:0];
                ly = py[6:0];
                exp_q.push_back({p, lx, ly});
                if (p) gold[px * 256 + py] = 1'b1;
            end
            oy++;
            if (d <= 0) d += 2 * oy + 1;
            else begin
                ox--;
                d += 2 * (oy - ox) + 1;
            end
        end
    endtask

    task automatic run_draw(input string tag, input int cx, input int cy, input int r,
                            input logic [7:0] mask, input int xmin, input int xmax,
                            input int ymin, input int ymax, input logic [2:0] col,
                            input bit drop_early);
        build_model(cx, cy, r, mask, xmin, xmax, ymin, ymax);
        @(negedge clk);
        bus.centre_x    = XW'(cx);
        bus.centre_y    = YW'(cy);
        bus.radius      = RW'(r);
        bus.colour      = col;
        bus.octant_mask = mask;
        bus.clip_xmin   = XW'(xmin);
        bus.clip_xmax   = XW'(xmax);
        bus.clip_ymin   = YW'(ymin);
        bus.clip_ymax   = YW'(ymax);
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        // Inputs after acceptance must have no effect.
        bus.centre_x    = XW'($urandom);
        bus.centre_y    = YW'($urandom);
        bus.radius      = RW'($urandom);
        bus.colour      = CW'($urandom);
        bus.octant_mask = 8'($urandom);
        bus.clip_xmin   = XW'($urandom);
        bus.clip_xmax   = XW'($urandom);
        bus.clip_ymin   = YW'($urandom);
        bus.clip_ymax   = YW'($urandom);
        if (drop_early) bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_init"}, {30'd0, bus.done, bus.vga_plot}, 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check({tag, "_pix"}, {13'd0, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour},
                  {13'd0, exp_q[i], col});
            if (bus.vga_plot === 1'b1) seen[int'(bus.vga_x) * 256 + int'(bus.vga_y)] = 1'b1;
        end
        @(negedge clk);
        check({tag, "_done_rise"}, {30'd0, bus.done, bus.vga_plot}, 32'd2);
        if (!drop_early) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check({tag, "_done_hold"}, {31'd0, bus.done}, 32'd1);
            end
            bus.start = 1'b0;
            @(negedge clk);
            check({tag, "_done_clear"}, {30'd0, bus.done, bus.vga_plot}, 32'd0);
        end else begin
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        end
    endtask

    initial begin
        int cnt;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.centre_x    = '0;
        bus.centre_y    = '0;
        bus.radius      = '0;
        bus.colour      = '0;
        bus.octant_mask = '0;
        bus.clip_xmin   = '0;
        bus.clip_xmax   = '0;
        bus.clip_ymin   = '0;
        bus.clip_ymax   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {13'd0, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
        rst = 1'b0;

        // Radius 0: eight writes at the centre.
        seen.delete();
        run_draw("r0", 80, 60, 0, 8'hFF, 0, 159, 0, 119, 3'd5, 1'b0);
        check("r0_npix", seen.num(), 32'd1);
        check("r0_centre", {31'd0, seen.exists(80 * 256 + 60)}, 32'd1);

        // Radius 1: two iterations, eight distinct pixels.
        seen.delete();
        run_draw("r1", 80, 60, 1, 8'hFF, 0, 159, 0, 119, 3'd2, 1'b0);
        check("r1_npix", seen.num(), 32'd8);
        check("r1_corner", {31'd0, seen.exists(81 * 256 + 59)}, 32'd1);

        // Lower half only via mask and clip.
        seen.delete();
        run_draw("r40m", 80, 60, 40, 8'h0F, 0, 159, 60, 119, 3'd7, 1'b0);
        check("r40m_right", {31'd0, seen.exists(120 * 256 + 60)}, 32'd1);
        cnt = 0;
        foreach (seen[k]) if ((k % 256) < 60) cnt++;
        check("r40m_upper_none", cnt, 32'd0);

        // Mostly off-screen circle; start dropped during PLOT.
        seen.delete();
        run_draw("offs", 5, 5, 20, 8'hFF, 0, 159, 0, 119, 3'd1, 1'b1);
        check("offs_right", {31'd0, seen.exists(25 * 256 + 5)}, 32'd1);
        check("offs_down", {31'd0, seen.exists(5 * 256 + 25)}, 32'd1);
        cnt = 0;
        foreach (seen[k]) if ((k / 256) >= SCREEN_W || (k % 256) >= SCREEN_H) cnt++;
        check("offs_no_wrap", cnt, 32'd0);

        // Reuleaux triangle on vertices A(60,80) B(100,80) C(80,45).
        seen.delete();
        gold.delete();
        run_draw("reu_a", 60, 80, 40, 8'hFF, 80, 100, 45, 80, 3'd4, 1'b0);
        run_draw("reu_b", 100, 80, 40, 8'hFF, 60, 80, 45, 80, 3'd4, 1'b0);
        run_draw("reu_c", 80, 45, 40, 8'hFF, 60, 100, 80, 119, 3'd4, 1'b0);
        check("reu_npix", seen.num(), gold.num());
        cnt = 0;
        foreach (gold[k]) if (!seen.exists(k)) cnt++;
        check("reu_missing", cnt, 32'd0);
        check("reu_vertex_a", {31'd0, seen.exists(60 * 256 + 80)}, 32'd1);
        check("reu_vertex_b", {31'd0, seen.exists(100 * 256 + 80)}, 32'd1);

        // Inverted clip window: nothing plotted, full latency.
        seen.delete();
        run_draw("inv", 80, 60, 10, 8'hFF, 100, 50, 0, 119, 3'd3, 1'b0);
        check("inv_npix", seen.num(), 32'd0);

        // Reset in the middle of a draw, at octant 3.
        @(negedge clk);
        bus.centre_x    = 8'd80;
        bus.centre_y    = 7'd60;
        bus.radius      = 8'd30;
        bus.colour      = 3'd6;
        bus.octant_mask = 8'hFF;
        bus.clip_xmin   = 8'd0;
        bus.clip_xmax   = 8'd159;
        bus.clip_ymin   = 7'd0;
        bus.clip_ymax   = 7'd119;
        bus.start       = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        check("mid_oct3_plot", {31'd0, bus.vga_plot}, 32'd1);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", {13'd0, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
        rst = 1'b0;
        run_draw("post_rst", 70, 50, 12, 8'hA5, 0, 159, 0, 119, 3'd6, 1'b0);

        // Randomized draws, including off-screen centres and inverted windows.
        for (int t = 0; t < 6; t++) begin
            run_draw("rand", $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 80),
                     8'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 127), $urandom_range(0, 127), 3'($urandom),
                     1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/clipped_arc.md
Name: clipped_arc

Overview:
- Parametrised successor to the fixed-size circle engine used by the fill-then-Reuleaux drawing flow.
- Draws a midpoint (Bresenham) circle into the VGA pixel stream, one candidate pixel per clock.
- Adds a per-octant enable mask, an inclusive rectangular clip window, and screen-size parameters, so a Reuleaux triangle or any arc figure is built from successive clipped_arc runs with no per-shape RTL.
- Sits between the top-level shape sequencer and the VGA adapter plot port.

Parameters:
- XW, 8, width of x coordinates.
- YW, 7, width of y coordinates.
- RW, 8, width of radius.
- CW, 3, width of colour.
- SCREEN_W, 160, visible columns; plotted x is in 0..SCREEN_W-1.
- SCREEN_H, 120, visible rows; plotted y is in 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; held high until done is seen
- done  out  1  drawing complete
- centre_x  in  XW  circle centre x
- centre_y  in  YW  circle centre y
- radius  in  RW  circle radius
- colour  in  CW  pixel colour
- octant_mask  in  8  bit k enables octant k
- clip_xmin, clip_xmax  in  XW  inclusive clip x bounds
- clip_ymin, clip_ymax  in  YW  inclusive clip y bounds
- vga_x  out  XW  pixel x
- vga_y  out  YW  pixel y
- vga_colour  out  CW  pixel colour
- vga_plot  out  1  write strobe

Behaviour:
- Reset: state IDLE; done, vga_plot, vga_x, vga_y and vga_colour all 0. Reset mid-draw aborts the draw and returns to IDLE on the next edge.
- States: IDLE -> INIT -> PLOT -> DONE -> IDLE.
- IDLE: when start=1, latch all data inputs (centre, radius, colour, mask, clip bounds) and go to INIT. Inputs changing after the latch are ignored.
- INIT (1 cycle): ox=radius, oy=0, crit=1-radius, oct=0.
- PLOT: oct counts 0..7, one cycle per octant. Candidate pixel by oct index:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-oy, cy+ox)
  - 3: (cx-ox, cy+oy)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+oy, cy-ox)
  - 7: (cx+ox, cy-oy)
- Candidate arithmetic: signed, width max(XW,YW,RW)+2; no wrap-around.
- vga_plot=1 only when all of these hold:
  - octant_mask[oct]=1
  - 0<=x<SCREEN_W and 0<=y<SCREEN_H
  - clip_xmin<=x<=clip_xmax and clip_ymin<=y<=clip_ymax
- vga_x/vga_y carry the low bits of the candidate in every PLOT cycle, whether or not vga_plot is asserted. vga_colour = latched colour.
- Masked or clipped candidates still consume their cycle, so latency is data-independent.
- On the oct=7 cycle, step the circle:
  - oy+=1
  - if crit<=0: crit+=2*oy+1 (using the new oy)
  - else: ox-=1, then crit+=2*(oy-ox)+1 (using the new values)
  - If new oy>new ox, go to DONE; else oct=0 and remain in PLOT.
- Latency: iterations N = number of (ox,oy) pairs with oy<=ox. First pixel appears in the cycle after INIT. done rises 1+8N+1 cycles after the start-accepting edge.
- DONE: done=1 and vga_plot=0. Held while start=1; start=0 returns to IDLE with done=0 on the next edge.
- start dropped during PLOT: the draw completes anyway. DONE then asserts done for exactly one cycle before IDLE.
- Boundary conditions:
  - radius=0: one iteration; all 8 candidates at the centre (duplicate writes allowed).
  - clip_xmin>clip_xmax or clip_ymin>clip_ymax: no plots, full latency.
  - octant_mask=0: no plots, full latency.
  - A candidate with negative or off-screen coordinates is never plotted, even if it lies inside the clip window.

Test Plan:
- Reset, then start with centre (80,60), r=0, mask FF, clip 0..159/0..119 -> 8 plot cycles all at (80,60) colour as given; done high 10 cycles after acceptance; done held while start=1; IDLE with done=0 one cycle after start drops.
- r=1, centre (80,60), mask FF, full clip:
  - -> N=2, 16 PLOT cycles.
  - First iteration plots (81,60),(80,61),(80,61),(79,60),(79,60),(80,59),(80,59),(81,60).
  - Second iteration plots (81,61),(81,61),(79,61),(79,61),(79,59),(79,59),(81,59),(81,59).
- r=40, centre (80,60), mask 0x0F, clip_ymin=60 -> no pixel with y<60 plotted; pixel (120,60) plotted; plot-cycle count unchanged versus mask FF.
- Off-screen: centre (5,5), r=20, full clip -> no plot with x or y negative or wrapped; (25,5) and (5,25) plotted.
- Reuleaux composition: three runs with r=40, each clipped to its opposite-vertex window -> the union of plotted pixels matches the golden Reuleaux pixel list; done handshake completes between runs.
- Assert rst during PLOT at oct=3 -> next cycle state IDLE, vga_plot=0, done=0; a new start is accepted normally.
